// File: rtl/pc_sequencer_if.sv
// Control/datapath bus of the PC sequencer: enables, PC sources, and the
// PC/status outputs seen by the control FSM and the memory address mux.
interface pc_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             pc_write;
    logic             pc_write_cond;
    logic             branch_ne;
    logic             alu_zero;
    logic [1:0]       pc_src;
    logic [31:0]      alu_result;
    logic [31:0]      alu_out;
    logic [25:0]      jump_field;
    logic             is_fetch;
    logic [31:0]      pc;
    logic [31:0]      pc_prev;
    logic             redirect;
    logic [CNT_W-1:0] fetch_count;
    logic             misalign_err;

    // Control side: drives enables/sources, observes the PC state.
    modport master (
        output pc_write, pc_write_cond, branch_ne, alu_zero, pc_src,
               alu_result, alu_out, jump_field, is_fetch,
        input  pc, pc_prev, redirect, fetch_count, misalign_err
    );

    // Sequencer side.
    modport slave (
        input  pc_write, pc_write_cond, branch_ne, alu_zero, pc_src,
               alu_result, alu_out, jump_field, is_fetch,
        output pc, pc_prev, redirect, fetch_count, misalign_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC register and next-PC select for the multi-cycle MIPS datapath.
// Optional macro PC_ALIGN_CHECK_EN: suppress misaligned loads and raise sticky misalign_err.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);
    localparam logic [1:0] SRC_ADD  = 2'b00;
    localparam logic [1:0] SRC_BR   = 2'b01;
    localparam logic [1:0] SRC_JMP  = 2'b10;

    logic [31:0]      pc_q;
    logic [31:0]      prev_q;
    logic             redirect_q;
    logic [CNT_W-1:0] count_q;

    logic [31:0] jump_target;
    logic [31:0] nxt_pc;
    logic        cond_ok;
    logic        take;
    logic        hold;
    logic        bad_align;
    logic        load;
    logic        is_redirect_src;

    // Jump keeps the current region (upper nibble) of the registered PC.
    assign jump_target = {pc_q[31:28], bus.jump_field, 2'b00};

    always_comb begin
        nxt_pc = pc_q;
        unique case (bus.pc_src)
            SRC_ADD: nxt_pc = bus.alu_result;
            SRC_BR:  nxt_pc = bus.alu_out;
            SRC_JMP: nxt_pc = jump_target;
            default: nxt_pc = pc_q;
        endcase
    end

    // BEQ takes on zero, BNE on non-zero; an unconditional write overrides both.
    assign cond_ok         = bus.alu_zero ^ bus.branch_ne;
    assign take            = bus.pc_write | (bus.pc_write_cond & cond_ok);
    assign hold            = (bus.pc_src == 2'b11);
    assign is_redirect_src = (bus.pc_src == SRC_BR) | (bus.pc_src == SRC_JMP);

`ifdef PC_ALIGN_CHECK_EN
    logic err_q;

    assign bad_align = take & ~hold & (nxt_pc[1:0] != 2'b00);
    assign load      = take & ~hold & ~bad_align;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (bad_align)
            err_q <= 1'b1;
    end

    assign bus.misalign_err = err_q;
`else
    assign bad_align        = 1'b0;
    assign load             = take & ~hold;
    assign bus.misalign_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            prev_q     <= RESET_PC;
            redirect_q <= 1'b0;
            count_q    <= '0;
        end else begin
            redirect_q <= load & is_redirect_src;
            if (load)
                pc_q <= nxt_pc;
            // Address of the instruction being fetched this cycle.
            if (bus.is_fetch & take)
                prev_q <= pc_q;
            if (bus.is_fetch & load & (bus.pc_src == SRC_ADD))
                count_q <= count_q + 1'b1;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_prev     = prev_q;
    assign bus.redirect    = redirect_q;
    assign bus.fetch_count = count_q;
endmodule
